// File: rtl/hilo_div_unit_pkg.sv
// Shared types and constants for the HI/LO register and divider block.
package hilo_pkg;

  // Number of restoring steps for a 32-bit divide.
  localparam int DIV_ITERS = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    ITER = 2'b10,
    FIX  = 2'b11
  } div_state_t;

  // MoveOp encodings; 2'b11 is reserved and behaves as a no-op.
  typedef enum logic [1:0] {
    MOVE_NONE = 2'b00,
    MOVE_MTHI = 2'b01,
    MOVE_MTLO = 2'b10,
    MOVE_RSVD = 2'b11
  } move_op_t;

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring divide datapath: partial remainder, quotient shift
// register and iteration counter. One quotient bit is produced per step.
module div_core_restoring
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = DIV_ITERS,
  parameter int CNT_W = $clog2(ITERS)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The difference always fits in WIDTH bits when the subtraction is taken.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, den_q});
    rem_next  = fits ? (rem_shift[WIDTH-1:0] - den_q) : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], fits};
  end

  // Datapath registers: load fresh operands, or advance one step.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      den_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO architectural register pair with ALU writes, MTHI/MTLO moves and a
// multi-cycle signed/unsigned restoring divider that writes its result to HI/LO.
//
// state | meaning
// IDLE  | accepting HiLoEn / MoveOp / DivStart
// PREP  | operands latched; take magnitudes, record result signs, detect /0
// ITER  | one restoring step per cycle, 32 steps
// FIX   | apply signs, write LO=quotient HI=remainder, pulse DivDone
module hilo_div_unit
  import hilo_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_HI   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_LO   = '0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    HiLoEn,
  input  logic [2*DATA_WIDTH-1:0] HiLoWrite,
  input  logic [1:0]              MoveOp,
  input  logic [DATA_WIDTH-1:0]   MoveData,
  input  logic                    DivStart,
  input  logic                    DivSigned,
  input  logic [DATA_WIDTH-1:0]   Dividend,
  input  logic [DATA_WIDTH-1:0]   Divisor,
  output logic [2*DATA_WIDTH-1:0] HiLoRead,
  output logic                    Busy,
  output logic                    DivDone,
  output logic                    DivByZero
);

  div_state_t state;

  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic                  signed_q;
  logic                  q_neg;
  logic                  r_neg;
  logic                  dz;
  logic                  busy_q;
  logic                  done_q;
  logic                  dz_pulse_q;

  logic [DATA_WIDTH-1:0] dvd_mag;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic                  core_load;
  logic                  core_step;
  logic [DATA_WIDTH-1:0] core_quo;
  logic [DATA_WIDTH-1:0] core_rem;
  logic                  core_last;

  // Magnitudes of the latched operands; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    dvd_mag   = (signed_q && dvd_q[DATA_WIDTH-1]) ? -dvd_q : dvd_q;
    dvs_mag   = (signed_q && dvs_q[DATA_WIDTH-1]) ? -dvs_q : dvs_q;
    core_load = (state == PREP) && (dvs_q != '0);
    core_step = (state == ITER);
  end

  div_core_restoring #(
    .WIDTH (DATA_WIDTH),
    .ITERS (DIV_ITERS)
  ) u_core (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (core_load),
    .step      (core_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (core_quo),
    .remainder (core_rem),
    .last      (core_last)
  );

  // Divider FSM plus HI/LO writes; a divide result outranks HiLoEn, which
  // outranks MoveOp. While busy, all external writes are dropped.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      hi         <= RESET_HI;
      lo         <= RESET_LO;
      dvd_q      <= '0;
      dvs_q      <= '0;
      signed_q   <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz         <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (HiLoEn) begin
            {hi, lo} <= HiLoWrite;
          end else begin
            case (move_op_t'(MoveOp))
              MOVE_MTHI: hi <= MoveData;
              MOVE_MTLO: lo <= MoveData;
              default:   ;
            endcase
          end
          if (DivStart) begin
            dvd_q    <= Dividend;
            dvs_q    <= Divisor;
            signed_q <= DivSigned;
            busy_q   <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          q_neg <= signed_q & (dvd_q[DATA_WIDTH-1] ^ dvs_q[DATA_WIDTH-1]);
          r_neg <= signed_q & dvd_q[DATA_WIDTH-1];
          dz    <= (dvs_q == '0);
          state <= (dvs_q == '0) ? FIX : ITER;
        end
        ITER: begin
          if (core_last) state <= FIX;
        end
        FIX: begin
          if (!dz) begin
            lo <= q_neg ? -core_quo : core_quo;
            hi <= r_neg ? -core_rem : core_rem;
          end
          done_q     <= 1'b1;
          dz_pulse_q <= dz;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HiLoRead  = {hi, lo};
  assign Busy      = busy_q;
  assign DivDone   = done_q;
  assign DivByZero = dz_pulse_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed scenarios plus randomized
// register writes and divides compared against an arithmetic reference model.
module tb_hilo_div_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic [1:0]  MoveOp;
  logic [31:0] MoveData;
  logic        DivStart;
  logic        DivSigned;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic [63:0] HiLoRead;
  logic        Busy;
  logic        DivDone;
  logic        DivByZero;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the architectural HI/LO contents.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 Clk = ~Clk;

  hilo_div_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .HiLoEn    (HiLoEn),
    .HiLoWrite (HiLoWrite),
    .MoveOp    (MoveOp),
    .MoveData  (MoveData),
    .DivStart  (DivStart),
    .DivSigned (DivSigned),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .HiLoRead  (HiLoRead),
    .Busy      (Busy),
    .DivDone   (DivDone),
    .DivByZero (DivByZero)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // MIPS divide semantics via 64-bit arithmetic: truncation toward zero,
  // remainder follows the dividend, result wraps modulo 2^32; /0 leaves HI/LO.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    m_lo = q[31:0];
    m_hi = r[31:0];
  endfunction

  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    HiLoEn    = 1'b1;
    HiLoWrite = {h, l};
    tick;
    HiLoEn    = 1'b0;
    m_hi      = h;
    m_lo      = l;
  endtask

  // Issue one divide and follow it to completion (bounded). busy_cyc counts
  // samples with Busy high starting right after the accepting edge; done_edge
  // is the number of edges after the accepting edge at which DivDone appeared.
  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int done_edge,
                        output int done_cnt, output bit dz_seen);
    int n;
    DivSigned = s;
    Dividend  = a;
    Divisor   = b;
    DivStart  = 1'b1;
    tick;
    DivStart  = 1'b0;
    busy_cyc  = 0;
    done_edge = -1;
    done_cnt  = 0;
    dz_seen   = 1'b0;
    n = 0;
    while (Busy && n < 60) begin
      busy_cyc++;
      tick;
      n++;
      if (DivDone) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
        if (DivByZero) dz_seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    tick;
    tick;
    m_hi = 32'h0;
    m_lo = 32'h0;
    vectors++;
    if (HiLoRead !== 64'h0) begin
      $display("FAIL reset_hilo: got %h expected %h", HiLoRead, 64'h0);
      miscompares++;
    end
    vectors++;
    if ({Busy, DivDone, DivByZero} !== 3'b000) begin
      $display("FAIL reset_flags: got busy/done/dz=%b expected 000", {Busy, DivDone, DivByZero});
      miscompares++;
    end
    Rst = 1'b1;
    tick;
  endtask

  task automatic test_hilo_write;
    logic [63:0] w;
    logic [31:0] d;
    logic        en;
    logic [1:0]  op;
    load_hilo(32'h00000001, 32'hFFFFFFFE);
    vectors++;
    if (HiLoRead !== 64'h00000001_FFFFFFFE) begin
      $display("FAIL hiloen_write: got %h expected %h", HiLoRead, 64'h00000001_FFFFFFFE);
      miscompares++;
    end
    MoveOp   = 2'b01;
    MoveData = 32'hDEADBEEF;
    tick;
    MoveOp   = 2'b00;
    vectors++;
    if (HiLoRead !== 64'hDEADBEEF_FFFFFFFE) begin
      $display("FAIL mthi: got %h expected %h", HiLoRead, 64'hDEADBEEF_FFFFFFFE);
      miscompares++;
    end
    MoveOp   = 2'b10;
    MoveData = 32'h12345678;
    tick;
    MoveOp   = 2'b00;
    vectors++;
    if (HiLoRead !== 64'hDEADBEEF_12345678) begin
      $display("FAIL mtlo: got %h expected %h", HiLoRead, 64'hDEADBEEF_12345678);
      miscompares++;
    end
    HiLoEn    = 1'b1;
    HiLoWrite = 64'hA5A5A5A5_5A5A5A5A;
    MoveOp    = 2'b01;
    MoveData  = 32'h0BADF00D;
    tick;
    HiLoEn = 1'b0;
    MoveOp = 2'b00;
    vectors++;
    if (HiLoRead !== 64'hA5A5A5A5_5A5A5A5A) begin
      $display("FAIL hiloen_beats_move: got %h expected %h", HiLoRead, 64'hA5A5A5A5_5A5A5A5A);
      miscompares++;
    end
    MoveOp   = 2'b11;
    MoveData = 32'hFFFF0000;
    tick;
    MoveOp = 2'b00;
    vectors++;
    if (HiLoRead !== 64'hA5A5A5A5_5A5A5A5A) begin
      $display("FAIL move_reserved: got %h expected %h", HiLoRead, 64'hA5A5A5A5_5A5A5A5A);
      miscompares++;
    end
    m_hi = 32'hA5A5A5A5;
    m_lo = 32'h5A5A5A5A;
    for (int i = 0; i < 16; i++) begin
      en = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      w  = {$urandom, $urandom};
      d  = $urandom;
      HiLoEn    = en;
      HiLoWrite = w;
      MoveOp    = op;
      MoveData  = d;
      tick;
      HiLoEn = 1'b0;
      MoveOp = 2'b00;
      if (en) {m_hi, m_lo} = w;
      else if (op == 2'b01) m_hi = d;
      else if (op == 2'b10) m_lo = d;
      vectors++;
      if (HiLoRead !== {m_hi, m_lo}) begin
        $display("FAIL rand_write[%0d]: got %h expected %h", i, HiLoRead, {m_hi, m_lo});
        miscompares++;
      end
    end
  endtask

  task automatic test_divu_basic;
    int bc, de, dc;
    bit dzs;
    do_div(1'b0, 32'd100, 32'd7, bc, de, dc, dzs);
    vectors++;
    if (bc !== 34 || de !== 34) begin
      $display("FAIL divu_latency: got busy=%0d done_edge=%0d expected 34/34", bc, de);
      miscompares++;
    end
    vectors++;
    if (HiLoRead !== 64'h00000002_0000000E) begin
      $display("FAIL divu_100_7: got %h expected %h", HiLoRead, 64'h00000002_0000000E);
      miscompares++;
    end
    vectors++;
    if (dc !== 1 || dzs !== 1'b0) begin
      $display("FAIL divu_done_flags: got done_cnt=%0d dz=%0b expected 1/0", dc, dzs);
      miscompares++;
    end
    m_hi = 32'd2;
    m_lo = 32'd14;
    tick;
    vectors++;
    if (DivDone !== 1'b0 || Busy !== 1'b0) begin
      $display("FAIL divu_done_pulse: got done=%b busy=%b expected 0/0", DivDone, Busy);
      miscompares++;
    end
  endtask

  task automatic test_div_signed;
    int bc, de, dc;
    bit dzs;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, bc, de, dc, dzs);
    vectors++;
    if (HiLoRead !== 64'hFFFFFFFF_FFFFFFFD) begin
      $display("FAIL div_m7_2: got %h expected %h", HiLoRead, 64'hFFFFFFFF_FFFFFFFD);
      miscompares++;
    end
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, bc, de, dc, dzs);
    vectors++;
    if (HiLoRead !== 64'h00000000_80000000) begin
      $display("FAIL div_min_m1: got %h expected %h", HiLoRead, 64'h00000000_80000000);
      miscompares++;
    end
    vectors++;
    if (bc !== 34 || dc !== 1) begin
      $display("FAIL div_min_m1_timing: got busy=%0d done_cnt=%0d expected 34/1", bc, dc);
      miscompares++;
    end
    m_hi = 32'h0;
    m_lo = 32'h80000000;
  endtask

  task automatic test_div_by_zero;
    int bc, de, dc;
    bit dzs;
    load_hilo(32'd5, 32'd6);
    do_div(1'b1, 32'd1234, 32'd0, bc, de, dc, dzs);
    vectors++;
    if (de !== 2 || bc !== 2) begin
      $display("FAIL dz_latency: got done_edge=%0d busy=%0d expected 2/2", de, bc);
      miscompares++;
    end
    vectors++;
    if (dzs !== 1'b1 || dc !== 1) begin
      $display("FAIL dz_flag: got dz=%0b done_cnt=%0d expected 1/1", dzs, dc);
      miscompares++;
    end
    vectors++;
    if (HiLoRead !== 64'h00000005_00000006) begin
      $display("FAIL dz_hilo_hold: got %h expected %h", HiLoRead, 64'h00000005_00000006);
      miscompares++;
    end
    tick;
    vectors++;
    if (DivByZero !== 1'b0 || DivDone !== 1'b0) begin
      $display("FAIL dz_pulse: got done=%b dz=%b expected 0/0", DivDone, DivByZero);
      miscompares++;
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    int de;
    load_hilo(32'h11111111, 32'h22222222);
    DivSigned = 1'b0;
    Dividend  = 32'd100;
    Divisor   = 32'd7;
    DivStart  = 1'b1;
    tick;
    DivStart = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    HiLoEn    = 1'b1;
    HiLoWrite = 64'hCAFEBABE_CAFEBABE;
    MoveOp    = 2'b10;
    MoveData  = 32'h33333333;
    DivStart  = 1'b1;
    Dividend  = 32'd9;
    Divisor   = 32'd3;
    tick;
    HiLoEn   = 1'b0;
    MoveOp   = 2'b00;
    DivStart = 1'b0;
    vectors++;
    if (HiLoRead !== 64'h11111111_22222222) begin
      $display("FAIL busy_drop_write: got %h expected %h", HiLoRead, 64'h11111111_22222222);
      miscompares++;
    end
    n  = 5;
    de = -1;
    while (de < 0 && n < 60) begin
      tick;
      n++;
      if (DivDone) de = n;
    end
    vectors++;
    if (de !== 34 || HiLoRead !== 64'h00000002_0000000E) begin
      $display("FAIL busy_ignore_result: got edge=%0d hilo=%h expected 34/%h", de, HiLoRead, 64'h00000002_0000000E);
      miscompares++;
    end
    tick;
    vectors++;
    if (Busy !== 1'b0) begin
      $display("FAIL busy_drop_start: got busy=%b expected 0", Busy);
      miscompares++;
    end
    m_hi = 32'd2;
    m_lo = 32'd14;
  endtask

  task automatic test_reset_mid;
    int dc;
    load_hilo(32'h44444444, 32'h55555555);
    DivSigned = 1'b1;
    Dividend  = 32'h7FFFFFFF;
    Divisor   = 32'd3;
    DivStart  = 1'b1;
    tick;
    DivStart = 1'b0;
    for (int i = 0; i < 11; i++) tick;
    Rst = 1'b0;
    tick;
    Rst = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    vectors++;
    if (Busy !== 1'b0 || DivDone !== 1'b0) begin
      $display("FAIL rst_mid_flags: got busy=%b done=%b expected 0/0", Busy, DivDone);
      miscompares++;
    end
    vectors++;
    if (HiLoRead !== 64'h0) begin
      $display("FAIL rst_mid_hilo: got %h expected %h", HiLoRead, 64'h0);
      miscompares++;
    end
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (DivDone || Busy) dc++;
    end
    vectors++;
    if (dc !== 0 || HiLoRead !== 64'h0) begin
      $display("FAIL rst_mid_aborted: got activity=%0d hilo=%h expected 0/%h", dc, HiLoRead, 64'h0);
      miscompares++;
    end
  endtask

  task automatic test_random_div;
    int bc, de, dc, exp_cyc;
    bit dzs, s;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      load_hilo($urandom, $urandom);
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(s, a, b, bc, de, dc, dzs);
      ref_div(s, a, b);
      exp_cyc = (b == 32'h0) ? 2 : 34;
      vectors++;
      if (HiLoRead !== {m_hi, m_lo}) begin
        $display("FAIL rand_div[%0d] s=%0b %h/%h: got %h expected %h", i, s, a, b, HiLoRead, {m_hi, m_lo});
        miscompares++;
      end
      vectors++;
      if (bc !== exp_cyc || de !== exp_cyc || dc !== 1 || dzs !== (b == 32'h0)) begin
        $display("FAIL rand_div_ctl[%0d]: got busy=%0d edge=%0d done=%0d dz=%0b expected %0d/%0d/1/%0b",
                 i, bc, de, dc, dzs, exp_cyc, exp_cyc, (b == 32'h0));
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, de;
    DivSigned = 1'b0;
    Dividend  = 32'd1000;
    Divisor   = 32'd10;
    DivStart  = 1'b1;
    tick;
    n  = 0;
    de = -1;
    while (de < 0 && n < 60) begin
      tick;
      n++;
      if (DivDone) de = n;
    end
    ref_div(1'b0, 32'd1000, 32'd10);
    vectors++;
    if (de !== 34 || Busy !== 1'b0 || HiLoRead !== {m_hi, m_lo}) begin
      $display("FAIL b2b_first: got edge=%0d busy=%b hilo=%h expected 34/0/%h", de, Busy, HiLoRead, {m_hi, m_lo});
      miscompares++;
    end
    DivSigned = 1'b1;
    Dividend  = 32'hFFFFFFCE;
    Divisor   = 32'd7;
    tick;
    DivStart = 1'b0;
    vectors++;
    if (Busy !== 1'b1 || DivDone !== 1'b0) begin
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", Busy, DivDone);
      miscompares++;
    end
    n  = 0;
    de = -1;
    while (de < 0 && n < 60) begin
      tick;
      n++;
      if (DivDone) de = n;
    end
    ref_div(1'b1, 32'hFFFFFFCE, 32'd7);
    vectors++;
    if (de !== 34 || HiLoRead !== {m_hi, m_lo}) begin
      $display("FAIL b2b_second: got edge=%0d hilo=%h expected 34/%h", de, HiLoRead, {m_hi, m_lo});
      miscompares++;
    end
  endtask

  initial begin
    Rst       = 1'b0;
    HiLoEn    = 1'b0;
    HiLoWrite = 64'h0;
    MoveOp    = 2'b00;
    MoveData  = 32'h0;
    DivStart  = 1'b0;
    DivSigned = 1'b0;
    Dividend  = 32'h0;
    Divisor   = 32'h0;
    m_hi      = 32'h0;
    m_lo      = 32'h0;

    test_reset();
    test_hilo_write();
    test_divu_basic();
    test_div_signed();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random_div();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
